// File: rtl/caxi4interconnect_sync_fifo_ctrl_pkg.sv
// caxi4interconnect_sync_fifo_ctrl_pkg: width helper shared by the sync FIFO controller files
package caxi4interconnect_sync_fifo_ctrl_pkg;
  function automatic int cnt_w(input int aw);
    return aw + 2;
  endfunction
endpackage

// File: rtl/caxi4interconnect_sync_fifo_ctrl_if.sv
// caxi4interconnect_sync_fifo_ctrl_if: push/pop ports and RAM-side bus of the sync FIFO controller
interface caxi4interconnect_sync_fifo_ctrl_if
  import caxi4interconnect_sync_fifo_ctrl_pkg::*;
#(parameter int AW = 4, parameter int W = 8);
  logic flush;
  logic wrValid;
  logic wrReady;
  logic [W-1:0] wrData;
  logic rdValid;
  logic rdReady;
  logic [W-1:0] rdData;
  logic [cnt_w(AW)-1:0] count;
  logic [AW-1:0] fifoWrAddr;
  logic fifoWrite;
  logic [W-1:0] fifoWrData;
  logic [AW-1:0] fifoRdAddr;
  logic [W-1:0] fifoRdData;
  modport slave (
    input flush, wrValid, wrData, rdReady, fifoRdData,
    output wrReady, rdValid, rdData, count, fifoWrAddr, fifoWrite, fifoWrData, fifoRdAddr
  );
  modport master (
    output flush, wrValid, wrData, rdReady, fifoRdData,
    input wrReady, rdValid, rdData, count, fifoWrAddr, fifoWrite, fifoWrData, fifoRdAddr
  );
endinterface

// File: rtl/caxi4interconnect_sync_fifo_ctrl_out_stage.sv
// caxi4interconnect_fifo_out_stage: 2-entry head/skid output buffer with in-order capture and pop
module caxi4interconnect_fifo_out_stage #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic         pop,
  input  logic [W-1:0] cap_data,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);
  logic [W-1:0] skid;
  logic [1:0] rem;
  assign rem = cnt - {1'b0, pop};
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      skid <= '0;
      cnt  <= '0;
    end else begin
      head <= (pop && cnt == 2'd2) ? skid : (cap && rem == 2'd0) ? cap_data : head;
      skid <= (cap && rem == 2'd1) ? cap_data : skid;
      cnt  <= rem + {1'b0, cap};
    end
endmodule

// File: rtl/caxi4interconnect_sync_fifo_ctrl.sv
// caxi4interconnect_sync_fifo_ctrl: RAM pointer/occupancy control with a FWFT output stage hiding read latency
module caxi4interconnect_sync_fifo_ctrl
  import caxi4interconnect_sync_fifo_ctrl_pkg::*;
#(
  parameter int HI_FREQ     = 1,
  parameter int FIFO_AWIDTH = 4,
  parameter int FIFO_WIDTH  = 8
) (
  input logic HCLK,
  input logic HRESET,
  caxi4interconnect_sync_fifo_ctrl_if.slave bus
);
  localparam int MW = FIFO_AWIDTH + 1;
  localparam int CW = cnt_w(FIFO_AWIDTH);
  localparam logic [MW-1:0] FULL = MW'(1 << FIFO_AWIDTH);
  logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [MW-1:0] mem_count;
  logic [1:0] out_count;
  logic in_flight, push, pop, fetch, cap, clear;
  assign clear = HRESET | bus.flush;
  assign bus.wrReady = !clear && mem_count != FULL;
  assign push = bus.wrValid & bus.wrReady;
  assign pop = bus.rdValid & bus.rdReady;
  // fetch only when the word will have a free output slot by the time it lands
  assign fetch = mem_count != '0 && (3'(out_count) + 3'(in_flight) < 3'd2 + 3'(pop));
  assign cap = (HI_FREQ != 0) ? in_flight : fetch;
  assign bus.rdValid = out_count != 2'd0;
  assign bus.count = CW'(mem_count) + CW'(in_flight) + CW'(out_count);
  assign bus.fifoWrAddr = wr_ptr;
  assign bus.fifoWrite = push;
  assign bus.fifoWrData = bus.wrData;
  assign bus.fifoRdAddr = rd_ptr;
  always_ff @(posedge HCLK)
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      in_flight <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + FIFO_AWIDTH'(push);
      rd_ptr    <= rd_ptr + FIFO_AWIDTH'(fetch);
      mem_count <= mem_count + MW'(push) - MW'(fetch);
      in_flight <= (HI_FREQ != 0) && fetch;
    end
  caxi4interconnect_fifo_out_stage #(.W(FIFO_WIDTH)) u_out (
    .clk(HCLK),
    .rst(clear),
    .cap(cap),
    .pop(pop),
    .cap_data(bus.fifoRdData),
    .head(bus.rdData),
    .cnt(out_count)
  );
endmodule
